// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer for a req/gnt/rvalid bus.
// Handles alignment traps, byte lanes, bus timeouts, flush kills and pipeline stall.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        resp_valid,
    output logic [31:0] resp_rdata_raw,
    output logic [1:0]  resp_addr_lsb2,
    output logic        trap_valid,
    output logic [30:0] trap_mcause
);

    // Op encoding; 0 and 9..15 are non-memory ops.
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [30:0] TRAP_CODE_LOAD_ADDR_MISALIGNED  = 31'd4;
    localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT     = 31'd5;
    localparam logic [30:0] TRAP_CODE_STORE_ADDR_MISALIGNED = 31'd6;
    localparam logic [30:0] TRAP_CODE_STORE_ACCESS_FAULT    = 31'd7;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_MISAL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        store_q, store_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        kill_q, kill_d;
    logic [15:0] cnt_q, cnt_d;

    logic        req_is_mem, req_is_store, req_is_half, req_is_word;
    logic        req_misal;
    logic [3:0]  req_strb;
    logic [15:0] cnt_inc;
    logic        timeout_hit;

    always_comb begin
        req_is_mem   = 1'b0;
        req_is_store = 1'b0;
        req_is_half  = 1'b0;
        req_is_word  = 1'b0;
        case (req_op)
            MEM_LB, MEM_LBU: req_is_mem = 1'b1;
            MEM_LH, MEM_LHU: begin req_is_mem = 1'b1; req_is_half = 1'b1; end
            MEM_LW:          begin req_is_mem = 1'b1; req_is_word = 1'b1; end
            MEM_SB:          begin req_is_mem = 1'b1; req_is_store = 1'b1; end
            MEM_SH:          begin req_is_mem = 1'b1; req_is_store = 1'b1; req_is_half = 1'b1; end
            MEM_SW:          begin req_is_mem = 1'b1; req_is_store = 1'b1; req_is_word = 1'b1; end
            default:         ;
        endcase
    end

    assign req_misal = (req_is_half & req_addr[0]) | (req_is_word & (|req_addr[1:0]));

    always_comb begin
        req_strb = 4'h0;
        if (req_is_store) begin
            if (req_is_word)      req_strb = 4'hF;
            else if (req_is_half) req_strb = 4'b0011 << req_addr[1:0];
            else                  req_strb = 4'b0001 << req_addr[1:0];
        end
    end

    assign cnt_inc     = cnt_q + 16'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        store_d = store_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (req_valid && req_is_mem && !flush) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                    wstrb_d = req_strb;
                    store_d = req_is_store;
                    err_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = req_misal ? ST_MISAL : ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d = cnt_inc;
                if (flush) kill_d = 1'b1;
                // A grant arriving on the timeout cycle is too late: the request is dropped.
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (dmem_gnt) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_inc;
                if (flush) kill_d = 1'b1;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata >> {addr_q[1:0], 3'b000};
                    err_d   = dmem_err;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP, ST_MISAL: begin
                kill_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            store_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req   = (state_q == ST_ADDR);
    assign dmem_we    = dmem_req & store_q;
    assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_wstrb = dmem_req ? wstrb_q : 4'h0;
    assign dmem_wdata = dmem_req ? wdata_q : 32'h0;

    assign resp_valid     = ((state_q == ST_RESP) || (state_q == ST_MISAL)) && !kill_q && !flush;
    assign trap_valid     = resp_valid && ((state_q == ST_MISAL) || err_q);
    assign resp_rdata_raw = rdata_q;
    assign resp_addr_lsb2 = addr_q[1:0];

    always_comb begin
        trap_mcause = '0;
        if (state_q == ST_MISAL)
            trap_mcause = store_q ? TRAP_CODE_STORE_ADDR_MISALIGNED : TRAP_CODE_LOAD_ADDR_MISALIGNED;
        else if ((state_q == ST_RESP) && err_q)
            trap_mcause = store_q ? TRAP_CODE_STORE_ACCESS_FAULT : TRAP_CODE_LOAD_ACCESS_FAULT;
    end

    // Gated by rst_n so every output reads 0 while reset is held.
    assign stall = rst_n && req_valid && req_is_mem && !resp_valid && !flush;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized ops against
// an arithmetic model of latency, traps, byte lanes and timeouts.
module tb_dmem_access_ctrl;

    localparam int T = 8;
    localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4;
    localparam logic [3:0] LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_err = 1'b0;
    logic        resp_valid, trap_valid;
    logic [31:0] resp_rdata_raw;
    logic [1:0]  resp_addr_lsb2;
    logic [30:0] trap_mcause;

    int n_checks = 0;
    int n_errors = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .resp_valid(resp_valid), .resp_rdata_raw(resp_rdata_raw),
        .resp_addr_lsb2(resp_addr_lsb2), .trap_valid(trap_valid), .trap_mcause(trap_mcause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // g: cycles GNT is withheld in ADDR; r: cycles RVALID is withheld in DATA.
    // flush_at: cycle index (0 = accept cycle) to pulse FLUSH and retire the op, -1 for none.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int g, input int r, input logic [31:0] rdata, input logic err,
                          input int flush_at, output logic [31:0] raw_o,
                          output logic [3:0] strb_o, output logic [31:0] wdata_o);
        int nb, lsb, c, resp_at, exp_req, fa, last_n;
        int seen_at, req_cycles, bus_bad, stall_bad, resp_count;
        bit st, misal, tmo, exp_trap, chk_raw, flushed, exp_stall;
        logic [30:0] exp_cause, got_cause;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_raw;
        logic        got_trap;
        logic [1:0]  got_lsb;

        nb  = op_bytes(op);
        st  = op_store(op);
        lsb = int'(addr[1:0]);
        misal = (lsb % nb) != 0;
        c   = g + 2 + r;
        tmo = !misal && ((g + 1 >= T) || (c > T));
        fa  = (misal || tmo) ? -1 : flush_at;
        flushed   = fa >= 0;
        exp_strb  = st ? 4'(((1 << nb) - 1) << lsb) : 4'h0;
        exp_wdata = wdata << (8 * lsb);
        exp_raw   = rdata >> (8 * lsb);
        chk_raw   = 1'b0;
        if (misal) begin
            resp_at = 1; exp_trap = 1'b1; exp_req = 0;
            exp_cause = st ? 31'd6 : 31'd4;
        end else if (tmo) begin
            resp_at = T + 1; exp_trap = 1'b1;
            exp_req = (g + 1 >= T) ? T : g + 1;
            exp_cause = st ? 31'd7 : 31'd5;
        end else begin
            resp_at = c + 1; exp_trap = err; exp_req = g + 1; chk_raw = 1'b1;
            exp_cause = st ? 31'd7 : 31'd5;
        end
        if (fa == 0) exp_req = 0;
        last_n = (fa == 0) ? 2 : c + 2;

        seen_at = -1; req_cycles = 0; bus_bad = 0; stall_bad = 0; resp_count = 0;
        raw_o = '0; strb_o = '0; wdata_o = '0; got_trap = 1'b0; got_cause = '0; got_lsb = '0;

        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            #1;
            req_valid   = !(flushed && n > fa);
            req_op      = op;
            req_addr    = addr;
            req_wdata   = wdata;
            flush       = flushed && (n == fa);
            dmem_gnt    = (n == g + 1);
            dmem_rvalid = (n == c);
            dmem_rdata  = (n == c) ? rdata : $urandom;
            dmem_err    = (n == c) ? err : 1'($urandom);
            @(negedge clk);
            exp_stall = req_valid && !flush && !(!flushed && n == resp_at);
            if (stall !== exp_stall) stall_bad++;
            if (dmem_req === 1'b1) begin
                req_cycles++;
                strb_o  = dmem_wstrb;
                wdata_o = dmem_wdata;
                if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== st ||
                    dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata)
                    bus_bad++;
            end
            if (resp_valid === 1'b1) begin
                resp_count++;
                if (seen_at < 0) begin
                    seen_at   = n;
                    got_trap  = trap_valid;
                    got_cause = trap_mcause;
                    raw_o     = resp_rdata_raw;
                    got_lsb   = resp_addr_lsb2;
                end
            end
            if (!flushed && resp_valid === 1'b1) break;
            if (flushed && n >= last_n) break;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        if (flushed) begin
            check_eq("flush_no_resp", resp_count, 0);
        end else begin
            check_eq("resp_cycle", seen_at, resp_at);
            check_eq("trap_valid", got_trap, exp_trap);
            if (exp_trap) check_eq("mcause", got_cause, exp_cause);
            check_eq("addr_lsb2", got_lsb, lsb);
            if (chk_raw) check_eq("rdata_raw", raw_o, exp_raw);
        end
        check_eq("req_cycles", req_cycles, exp_req);
        check_eq("bus_fields_bad", bus_bad, 0);
        check_eq("stall_bad", stall_bad, 0);
        $display("txn op=%0d addr=%08h g=%0d r=%0d flush_at=%0d resp@%0d trap=%0b cause=%0d raw=%08h",
                 op, addr, g, r, fa, seen_at, got_trap, got_cause, raw_o);
    endtask

    initial begin
        logic [31:0] raw, wd, a;
        logic [3:0]  strb, op;
        int g, r, fa, bad;

        // Reset state, with a memory op presented to exercise stall gating.
        req_valid = 1'b1; req_op = LW;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {stall, dmem_req, dmem_we, resp_valid, trap_valid, dmem_wstrb, resp_addr_lsb2}, 0);
        check_eq("rst_addr_wdata", {dmem_addr, dmem_wdata}, 0);
        check_eq("rst_raw_cause", {resp_rdata_raw, trap_mcause}, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        run_op(LW, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, -1, raw, strb, wd);
        check_eq("lw_raw", raw, 32'hDEADBEEF);

        run_op(LB, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0, -1, raw, strb, wd);
        check_eq("lb_raw", raw, 32'h00000080);
        check_eq("lb_load_unit", {{24{raw[7]}}, raw[7:0]}, 32'hFFFFFF80);

        run_op(SH, 32'h202, 32'h0000ABCD, 0, 0, 32'h0, 1'b0, -1, raw, strb, wd);
        check_eq("sh_wstrb", strb, 4'b1100);
        check_eq("sh_wdata", wd, 32'hABCD0000);

        run_op(LH, 32'h201, 32'h0, 0, 0, 32'h0, 1'b0, -1, raw, strb, wd);
        run_op(SW, 32'h300, 32'h12345678, 5, 0, 32'h0, 1'b1, -1, raw, strb, wd);
        run_op(LW, 32'h400, 32'h0, 0, 100, 32'h0, 1'b0, -1, raw, strb, wd);

        // Late RVALID after the timeout must not produce a response.
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            dmem_rvalid = 1'b1; dmem_err = 1'b1;
            @(negedge clk);
            if (resp_valid !== 1'b0 || trap_valid !== 1'b0 || dmem_req !== 1'b0) bad++;
        end
        dmem_rvalid = 1'b0; dmem_err = 1'b0;
        check_eq("stray_rvalid", bad, 0);

        run_op(LW, 32'h500, 32'h0, 0, 2, 32'h55, 1'b0, 2, raw, strb, wd);
        run_op(LW, 32'h504, 32'h0, 0, 0, 32'h66, 1'b0, 2, raw, strb, wd);
        run_op(SB, 32'h508, 32'hAA, 1, 0, 32'h0, 1'b0, 0, raw, strb, wd);
        run_op(LBU, 32'h601, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0, -1, raw, strb, wd);

        // Non-memory op: no stall, no bus activity.
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1; req_op = 4'd0;
            @(negedge clk);
            if (stall !== 1'b0 || dmem_req !== 1'b0) bad++;
        end
        check_eq("non_mem_op", bad, 0);

        // Asynchronous reset while the request is outstanding.
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = LW; req_addr = 32'h700;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("pre_reset_req", dmem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ctrl", {stall, dmem_req, dmem_we, resp_valid, trap_valid, dmem_wstrb, resp_addr_lsb2}, 0);
        check_eq("midrst_addr_wdata", {dmem_addr, dmem_wdata}, 0);
        check_eq("midrst_raw_cause", {resp_rdata_raw, trap_mcause}, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(LW, 32'h800, 32'h0, 0, 0, 32'h01020304, 1'b0, -1, raw, strb, wd);

        for (int k = 0; k < 60; k++) begin
            op = 4'(1 + $urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op_bytes(op) == 4)      a[1:0] = 2'b00;
                else if (op_bytes(op) == 2) a[0] = 1'b0;
            end
            g  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 2));
            r  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 2));
            fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, g + 2 + r)) : -1;
            run_op(op, a, $urandom, g, r, $urandom, ($urandom_range(0, 5) == 0), fa, raw, strb, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
